// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul APB front-end.
// Bus geometry, region map, CONTROL layout and APB FSM states.
package matmul_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int BUS_WIDTH  = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int LINE_W     = ADDR_WIDTH - 5;
  localparam int IDX_W      = $clog2(MAX_DIM);
  localparam int SP_AW      = $clog2(MAX_DIM * MAX_DIM);

  localparam logic [4:0] REG_CONTROL = 5'h00;
  localparam logic [4:0] REG_OPA     = 5'h04;
  localparam logic [4:0] REG_OPB     = 5'h08;
  localparam logic [4:0] REG_FLAGS   = 5'h0C;
  localparam logic [4:0] REG_SP0     = 5'h10;
  localparam logic [4:0] REG_SP1     = 5'h14;
  localparam logic [4:0] REG_SP2     = 5'h18;
  localparam logic [4:0] REG_SP3     = 5'h1C;

  // Writable CONTROL bits; start and reserved bits never stored.
  localparam logic [15:0] CTRL_MASK = 16'h3F3E;

  typedef struct packed {
    logic [1:0] rsv1;
    logic [1:0] m;
    logic [1:0] k;
    logic [1:0] n;
    logic [1:0] rsv0;
    logic [1:0] read_target;
    logic [1:0] write_target;
    logic       mode;
    logic       start;
  } ctrl_reg_t;

  typedef struct packed {
    logic sp;
    logic flags;
    logic opb;
    logic opa;
    logic ctrl;
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_WAIT   = 2'd3
  } apb_state_t;

  function automatic logic [BUS_WIDTH-1:0] lane_merge(
    input logic [BUS_WIDTH-1:0] old_v,
    input logic [BUS_WIDTH-1:0] new_v,
    input logic [MAX_DIM-1:0]   strb
  );
    logic [BUS_WIDTH-1:0] v;
    v = old_v;
    for (int l = 0; l < MAX_DIM; l++)
      if (strb[l])
        v[l*DATA_WIDTH +: DATA_WIDTH] = new_v[l*DATA_WIDTH +: DATA_WIDTH];
    return v;
  endfunction

  function automatic ctrl_reg_t ctrl_merge(
    input ctrl_reg_t   old_v,
    input logic [15:0] new_v,
    input logic [1:0]  strb
  );
    logic [15:0] v;
    v = old_v;
    if (strb[0]) v[7:0]  = new_v[7:0];
    if (strb[1]) v[15:8] = new_v[15:8];
    return ctrl_reg_t'(v & CTRL_MASK);
  endfunction

endpackage

// File: rtl/matmul_apb_decode.sv
// Combinational APB address/access decode for the matmul front-end.
// In: paddr/pwrite/busy. Out: region one-hot, line, sp select, err.
module matmul_apb_decode
  import matmul_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  pwrite_i,
  input  logic                  busy_i,
  output region_t               region_o,
  output logic [SP_AW-1:0]      line_o,
  output logic [1:0]            sp_sel_o,
  output logic                  err_o
);

  logic [4:0]        w_reg;
  logic [LINE_W-1:0] w_line;
  logic              w_lim_op;
  logic              w_lim_sp;
  logic              w_zero;
  logic              w_wr_busy;
  logic              w_ok;

  assign w_reg     = paddr_i[4:0];
  assign w_line    = paddr_i[ADDR_WIDTH-1:5];
  assign line_o    = w_line[SP_AW-1:0];
  assign sp_sel_o  = paddr_i[3:2];
  assign w_lim_op  = w_line < LINE_W'(MAX_DIM);
  assign w_lim_sp  = w_line < LINE_W'(MAX_DIM * MAX_DIM);
  assign w_zero    = w_line == '0;
  assign w_wr_busy = pwrite_i & busy_i;

  always_comb begin
    region_o = '0;
    unique case (w_reg)
      REG_CONTROL: region_o.ctrl  = 1'b1;
      REG_OPA:     region_o.opa   = 1'b1;
      REG_OPB:     region_o.opb   = 1'b1;
      REG_FLAGS:   region_o.flags = 1'b1;
      REG_SP0, REG_SP1,
      REG_SP2, REG_SP3:
                   region_o.sp    = 1'b1;
      default:     region_o       = '0;
    endcase
  end

  always_comb begin
    w_ok = 1'b0;
    unique case (1'b1)
      region_o.ctrl:  w_ok = w_zero & ~w_wr_busy;
      region_o.opa:   w_ok = w_lim_op & ~w_wr_busy;
      region_o.opb:   w_ok = w_lim_op & ~w_wr_busy;
      region_o.flags: w_ok = w_zero & ~pwrite_i;
      region_o.sp:    w_ok = w_lim_sp & ~pwrite_i;
      default:        w_ok = 1'b0;
    endcase
  end

  assign err_o = ~w_ok;

endmodule

// File: rtl/matmul_apb_slave.sv
// APB slave front-end of the matmul accelerator: FSM, regs, read mux.
// APB in/out, start/ctrl/operands to core, scratchpad read port.
module matmul_apb_slave
  import matmul_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [MAX_DIM-1:0]           pstrb_i,
  input  logic [BUS_WIDTH-1:0]         pwdata_i,
  input  logic [ADDR_WIDTH-1:0]        paddr_i,
  output logic [BUS_WIDTH-1:0]         prdata_o,
  output logic                         pready_o,
  output logic                         pslverr_o,
  input  logic                         busy_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]   flags_i,
  output logic                         start_o,
  output logic [15:0]                  ctrl_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] operand_a_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] operand_b_o,
  output logic                         sp_rd_en_o,
  output logic [1:0]                   sp_rd_sel_o,
  output logic [SP_AW-1:0]             sp_rd_addr_o,
  input  logic [BUS_WIDTH-1:0]         sp_rd_data_i
);

  apb_state_t           r_state;
  ctrl_reg_t            r_ctrl;
  logic [BUS_WIDTH-1:0] r_op_a [MAX_DIM];
  logic [BUS_WIDTH-1:0] r_op_b [MAX_DIM];
  logic [BUS_WIDTH-1:0] r_prdata;
  logic [BUS_WIDTH-1:0] r_sp_data;
  logic                 r_start;

  region_t              w_region;
  logic [SP_AW-1:0]     w_line;
  logic [1:0]           w_sp_sel;
  logic                 w_err;
  apb_state_t           w_state;
  apb_state_t           w_next;
  logic                 w_sp_rd;
  logic                 w_done;
  logic                 w_wr;
  logic [IDX_W-1:0]     w_idx;
  logic [BUS_WIDTH-1:0] w_rdata;

  matmul_apb_decode u_dec (
    .paddr_i  (paddr_i),
    .pwrite_i (pwrite_i),
    .busy_i   (busy_i),
    .region_o (w_region),
    .line_o   (w_line),
    .sp_sel_o (w_sp_sel),
    .err_o    (w_err)
  );

  assign w_idx   = w_line[IDX_W-1:0];
  assign w_sp_rd = w_region.sp & ~pwrite_i & ~w_err;
  assign w_done  = (r_state == ST_ACCESS) & psel_i & penable_i;
  assign w_wr    = w_done & pwrite_i & ~w_err;

  // The setup phase is seen live on the bus so the scratchpad
  // request can go out in the same cycle.
  always_comb begin
    w_state = r_state;
    if (rst_ni && r_state == ST_IDLE && psel_i && !penable_i)
      w_state = ST_SETUP;
  end

  always_comb begin
    w_next = ST_IDLE;
    unique case (w_state)
      ST_IDLE:   w_next = ST_IDLE;
      ST_SETUP:  w_next = w_sp_rd ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   w_next = psel_i ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_next = (!psel_i || penable_i) ? ST_IDLE : ST_ACCESS;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    if (!pwrite_i && !w_err) begin
      unique case (1'b1)
        w_region.ctrl:  w_rdata = BUS_WIDTH'(r_ctrl);
        w_region.opa:   w_rdata = r_op_a[w_idx];
        w_region.opb:   w_rdata = r_op_b[w_idx];
        w_region.flags: w_rdata = BUS_WIDTH'(flags_i);
        w_region.sp:    w_rdata = r_sp_data;
        default:        w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= '0;
      r_prdata  <= '0;
      r_sp_data <= '0;
      r_start   <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
        r_op_a[i] <= '0;
        r_op_b[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_start <= 1'b0;
      if (r_state == ST_WAIT)
        r_sp_data <= sp_rd_data_i;
      if (w_done)
        r_prdata <= w_rdata;
      if (w_wr) begin
        unique case (1'b1)
          w_region.ctrl: begin
            r_ctrl  <= ctrl_merge(r_ctrl, pwdata_i[15:0],
                                  pstrb_i[1:0]);
            r_start <= pstrb_i[0] & pwdata_i[0];
          end
          w_region.opa:
            r_op_a[w_idx] <= lane_merge(r_op_a[w_idx],
                                        pwdata_i, pstrb_i);
          w_region.opb:
            r_op_b[w_idx] <= lane_merge(r_op_b[w_idx],
                                        pwdata_i, pstrb_i);
          default: ;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_op
    assign operand_a_o[gi*BUS_WIDTH +: BUS_WIDTH] = r_op_a[gi];
    assign operand_b_o[gi*BUS_WIDTH +: BUS_WIDTH] = r_op_b[gi];
  end

  assign prdata_o     = w_done ? w_rdata : r_prdata;
  assign pready_o     = w_done;
  assign pslverr_o    = w_done & w_err;
  assign start_o      = r_start;
  assign ctrl_o       = r_ctrl;
  assign sp_rd_en_o   = (w_state == ST_SETUP) & w_sp_rd;
  assign sp_rd_sel_o  = w_sp_sel;
  assign sp_rd_addr_o = w_line;

endmodule
